dmem_lsu: RTL and testbench

- Load/store initiator between the core's memory stage and the byte-addressed data memory port.
- Accepts one load or store request at a time and decodes it into byte enables and lane-replicated write data.
- Drives the memory's EN/WE/ADDR/WDATA signals and waits for RVALID on loads.
- Returns lane-aligned, sign- or zero-extended load data, or an error for misaligned accesses.

---
 rtl/dmem_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store initiator between the core memory stage and a byte-addressed data memory.
// Optional READ timeout guarded by LSU_TIMEOUT_EN (disabled by default).
module dmem_lsu #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_UNSIGNED,
    input  logic [31:0]           REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [31:0]           RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  MEM_EN,
    output logic [3:0]            MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [31:0]           MEM_WDATA,
    input  logic [31:0]           MEM_RDATA,
    input  logic                  MEM_RVALID
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_en_q, mem_en_d;
    logic [3:0]              mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              off_q, off_d;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    logic                    misaligned;
    logic [3:0]              size_mask;
    logic [31:0]             wdata_rep;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [31:0]             rd_ext;

    logic unused_addr_hi;
    assign unused_addr_hi = ^REQ_ADDR[31:ADDR_WIDTH];

    // Request decode operates on the live request fields (used only on acceptance).
    always_comb begin
        misaligned = (REQ_SIZE == 2'd3)
                  || ((REQ_SIZE == 2'd1) && REQ_ADDR[0])
                  || ((REQ_SIZE == 2'd2) && (REQ_ADDR[1:0] != 2'b00));
        case (REQ_SIZE)
            2'd0:    begin size_mask = 4'b0001; wdata_rep = {4{REQ_WDATA[7:0]}};  end
            2'd1:    begin size_mask = 4'b0011; wdata_rep = {2{REQ_WDATA[15:0]}}; end
            default: begin size_mask = 4'b1111; wdata_rep = REQ_WDATA;            end
        endcase
    end

    // Load extraction uses the request fields captured at acceptance.
    always_comb begin
        rd_byte = MEM_RDATA[{off_q, 3'b000} +: 8];
        rd_half = MEM_RDATA[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    rd_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    rd_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = MEM_RDATA;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    mem_addr_d  = REQ_ADDR[ADDR_WIDTH-1:0];
                    mem_wdata_d = wdata_rep;
                    size_d      = REQ_SIZE;
                    uns_d       = REQ_UNSIGNED;
                    off_d       = REQ_ADDR[1:0];
                    if (misaligned) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (REQ_WE) begin
                        state_d  = ST_WRITE;
                        mem_en_d = 1'b1;
                        mem_we_d = size_mask << REQ_ADDR[1:0];
                    end else begin
                        state_d  = ST_READ;
                        mem_en_d = 1'b1;
`ifdef LSU_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            ST_READ: begin
                mem_en_d = 1'b1;
                if (MEM_RVALID) begin
                    state_d     = ST_RESP;
                    mem_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = rd_ext;
                end
`ifdef LSU_TIMEOUT_EN
                // RVALID takes priority over a timeout reached in the same cycle.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_RESP;
                    mem_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign REQ_READY = (state_q == ST_IDLE) && !RST;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign MEM_EN    = mem_en_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a small byte-write memory model.
// Expects TIMEOUT_CYCLES=4 behaviour when LSU_TIMEOUT_EN is defined.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr, prev_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_rvalid;
    logic        hold;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

`ifdef LSU_TIMEOUT_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 5;
`endif

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(4)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .MEM_RVALID(mem_rvalid)
    );

    // Memory: RVALID once the address has been stable for a cycle with EN high.
    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_rvalid = !hold && mem_en && (mem_addr == prev_addr);

    always @(posedge clk) begin
        prev_addr <= mem_addr;
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Returns cycles from acceptance to RSP_VALID, or -1 if it never came.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (rsp_valid !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_en} !== 4'b0000 || mem_we !== 4'h0 ||
            rsp_rdata !== 32'h0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b en=%b we=%b expected all zero",
                     req_ready, rsp_valid, mem_en, mem_we);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_store_word();
        int cyc;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL st_ready: got %b expected 1", req_ready); end
        send(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 4'b1111 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 10'h010) begin
            errors++;
            $display("FAIL st_word_t1: got en=%b we=%b wd=%h a=%h expected 1 1111 deadbeef 010",
                     mem_en, mem_we, mem_wdata, mem_addr);
        end
        wait_rsp(cyc);
        checks++;
        if (cyc != 2 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL st_word_rsp: got lat=%0d err=%b rd=%h expected 2 0 0", cyc, rsp_err, rsp_rdata);
        end
        send(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
        wait_rsp(cyc);
        checks++;
        if (cyc != 2 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ld_word_back: got lat=%0d rd=%h err=%b expected 2 deadbeef 0", cyc, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_byte();
        int cyc;
        send(1'b1, 2'd0, 1'b0, 32'h013, 32'h1234567A);
        checks++;
        if (mem_we !== 4'b1000 || mem_wdata !== 32'h7A7A7A7A) begin
            errors++;
            $display("FAIL st_byte: got we=%b wd=%h expected 1000 7a7a7a7a", mem_we, mem_wdata);
        end
        wait_rsp(cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL st_byte_lat: got %0d expected 2", cyc); end
        checks++;
        if (mem[4] !== 32'h7AADBEEF) begin
            errors++; $display("FAIL st_byte_mem: got %h expected 7aadbeef", mem[4]);
        end
        mem[4] = 32'h80000000;
        send(1'b0, 2'd0, 1'b0, 32'h013, 32'h0);
        wait_rsp(cyc);
        checks++;
        if (cyc != 2 || rsp_rdata !== 32'hFFFFFF80) begin
            errors++; $display("FAIL ld_byte_s: got lat=%0d rd=%h expected 2 ffffff80", cyc, rsp_rdata);
        end
        send(1'b0, 2'd0, 1'b1, 32'h013, 32'h0);
        wait_rsp(cyc);
        checks++;
        if (rsp_rdata !== 32'h00000080) begin
            errors++; $display("FAIL ld_byte_u: got %h expected 00000080", rsp_rdata);
        end
    endtask

    task automatic test_half();
        int cyc;
        mem[8] = 32'h80011234;
        send(1'b0, 2'd1, 1'b0, 32'h022, 32'h0);
        wait_rsp(cyc);
        checks++;
        if (cyc != 3 || rsp_rdata !== 32'hFFFF8001) begin
            errors++; $display("FAIL ld_half_hi: got lat=%0d rd=%h expected 3 ffff8001", cyc, rsp_rdata);
        end
        send(1'b0, 2'd1, 1'b0, 32'h020, 32'h0);
        wait_rsp(cyc);
        checks++;
        if (rsp_rdata !== 32'h00001234) begin
            errors++; $display("FAIL ld_half_lo: got %h expected 00001234", rsp_rdata);
        end
        send(1'b1, 2'd1, 1'b0, 32'h022, 32'h0000ABCD);
        checks++;
        if (mem_we !== 4'b1100 || mem_wdata !== 32'hABCDABCD) begin
            errors++; $display("FAIL st_half: got we=%b wd=%h expected 1100 abcdabcd", mem_we, mem_wdata);
        end
        wait_rsp(cyc);
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ad [3] = '{32'h021, 32'h026, 32'h020};
        for (int i = 0; i < 3; i++) begin
            send(1'b0, sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || mem_en !== 1'b0) begin
                errors++;
                $display("FAIL misalign_%0d_t1: got v=%b err=%b rd=%h en=%b expected 1 1 0 0",
                         i, rsp_valid, rsp_err, rsp_rdata, mem_en);
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || mem_en !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL misalign_%0d_t2: got v=%b err=%b en=%b rdy=%b expected 0 1 0 1",
                         i, rsp_valid, rsp_err, mem_en, req_ready);
            end
        end
    endtask

    task automatic test_stall();
        mem[12] = 32'h000000A5;
        hold = 1'b1;
        send(1'b0, 2'd2, 1'b0, 32'h030, 32'h0);
        for (int i = 0; i < STALL; i++) begin
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 10'h030 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got en=%b a=%h v=%b rdy=%b expected 1 030 0 0",
                         i, mem_en, mem_addr, rsp_valid, req_ready);
            end
            @(negedge clk);
        end
        hold = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000A5 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_rsp: got v=%b rd=%h err=%b expected 1 000000a5 0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        hold = 1'b1;
        send(1'b0, 2'd2, 1'b0, 32'h040, 32'h0);
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rmid_en: got %b expected 1", mem_en); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || req_ready !== 1'b0 || mem_addr !== 10'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got en=%b rdy=%b a=%h v=%b expected 0 0 000 0",
                     mem_en, req_ready, mem_addr, rsp_valid);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; hold = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_en !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp: got activity=%b expected 0", seen); end
    endtask

    task automatic test_timeout();
        int cyc;
        hold = 1'b1;
        send(1'b0, 2'd2, 1'b0, 32'h050, 32'h0);
`ifdef LSU_TIMEOUT_EN
        wait_rsp(cyc);
        checks++;
        if (cyc != 5 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_rsp: got lat=%0d err=%b rd=%h expected 5 1 0", cyc, rsp_err, rsp_rdata);
        end
        hold = 1'b0;
`else
        begin
            logic bad;
            bad = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (rsp_valid !== 1'b0 || mem_en !== 1'b1) bad = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (bad !== 1'b0) begin errors++; $display("FAIL no_timeout_hold: got left READ=%b expected 0", bad); end
            hold = 1'b0;
            wait_rsp(cyc);
            checks++;
            if (cyc < 0 || rsp_err !== 1'b0) begin
                errors++; $display("FAIL no_timeout_rsp: got lat=%0d err=%b expected valid 0", cyc, rsp_err);
            end
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_store_word();
        test_byte();
        test_half();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
